// File: rtl/flag_branch_unit.sv
// Architectural flag register, branch-condition evaluator and flag save/restore
// LIFO for the MicroUAZ sequencer. ALU flags are forwarded into the same cycle.
module flag_branch_unit #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] flags_in,
  input  logic       flag_we,
  input  logic       branch_req,
  input  logic [2:0] cond,
  input  logic       push,
  input  logic       pop,
  output logic [2:0] flags_q,
  output logic       branch_valid,
  output logic       branch_taken,
  output logic       stack_empty,
  output logic       stack_full,
  output logic       stack_err
);

  localparam logic [PTR_W-1:0] SP_MAX = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] SP_ONE = PTR_W'(1);

  // Sized to the full pointer range so sp indexes it without truncation.
  logic [2:0]       stack [2**PTR_W];
  logic [PTR_W-1:0] sp;
  logic [PTR_W-1:0] sp_next_p0;
  logic [2:0]       eff_p0;
  logic             hit_p0;
  logic             push_ok_p0;
  logic             pop_ok_p0;
  logic             err_p0;

  // Flag layout: [0]=C, [1]=Z, [2]=N.
  function automatic logic cond_hit(input logic [2:0] c, input logic [2:0] f);
    logic r;
    case (c)
      3'b000:  r = 1'b1;
      3'b001:  r = f[1];
      3'b010:  r = ~f[1];
      3'b011:  r = f[0];
      3'b100:  r = ~f[0];
      3'b101:  r = f[2];
      3'b110:  r = ~f[2];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  always_comb begin
    eff_p0     = flag_we ? flags_in : flags_q;
    hit_p0     = cond_hit(cond, eff_p0);
    push_ok_p0 = push & ~pop & (sp != SP_MAX);
    pop_ok_p0  = pop & ~push & (sp != '0);
    err_p0     = (push | pop) & ~push_ok_p0 & ~pop_ok_p0;
    sp_next_p0 = sp;
    if (push_ok_p0)
      sp_next_p0 = sp + SP_ONE;
    else if (pop_ok_p0)
      sp_next_p0 = sp - SP_ONE;
  end

  // Stage p0 -> registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q      <= 3'b000;
      branch_valid <= 1'b0;
      branch_taken <= 1'b0;
      sp           <= '0;
      stack_empty  <= 1'b1;
      stack_full   <= 1'b0;
      stack_err    <= 1'b0;
    end else begin
      branch_valid <= branch_req;
      if (branch_req)
        branch_taken <= hit_p0;
      if (pop_ok_p0)
        flags_q <= stack[sp - SP_ONE];
      else if (flag_we)
        flags_q <= flags_in;
      sp          <= sp_next_p0;
      stack_empty <= (sp_next_p0 == '0);
      stack_full  <= (sp_next_p0 == SP_MAX);
      stack_err   <= err_p0;
    end
  end

  // Stack storage is data only; contents after reset are don't-care.
  always_ff @(posedge clk) begin
    if (!rst && push_ok_p0)
      stack[sp] <= eff_p0;
  end

endmodule

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
- Consumer end of the ALU flag interface. Latches the 3-bit ALU flag vector into an architectural flag register, evaluates branch conditions against it, and saves/restores flags on a small LIFO for interrupt/call entry and exit.
- Sits between the ALU flag generator and the sequencer/PC logic of the 8-bit MicroUAZ core.

Parameters:
- DEPTH, 4, number of flag-stack entries (2..16)
- PTR_W, 3, stack pointer width; must satisfy 2^PTR_W > DEPTH

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- flags_in  input  3  ALU flags: [0]=C carry, [1]=Z zero, [2]=N negative
- flag_we  input  1  load flags_in into flag register
- branch_req  input  1  request branch evaluation this cycle
- cond  input  3  condition code, sampled with branch_req
- push  input  1  push current flags onto stack
- pop  input  1  restore flags from top of stack
- flags_q  output  3  architectural flag register
- branch_valid  output  1  one-cycle pulse; branch_taken is meaningful
- branch_taken  output  1  evaluated condition result
- stack_empty  output  1  no entries
- stack_full  output  1  DEPTH entries
- stack_err  output  1  one-cycle pulse on an illegal stack operation

Behaviour:
- Reset (async, immediate): flags_q=000, branch_valid=0, branch_taken=0, sp=0, stack_empty=1, stack_full=0, stack_err=0. Stack contents are don't-care.
- Effective flags (eff): flags_in when flag_we=1, else flags_q. ALU results are forwarded with no stall.
- Condition codes, evaluated on eff:
  - 000 always
  - 001 Z=1
  - 010 Z=0
  - 011 C=1
  - 100 C=0
  - 101 N=1
  - 110 N=0
  - 111 never
- Branch latency: 1 cycle. branch_req at edge k gives branch_valid=1 and branch_taken=result during cycle k+1.
- Without a new request: branch_valid returns to 0 and branch_taken holds its last value. Back-to-back requests produce back-to-back pulses.
- Flag register priority, highest first:
  1. legal pop: flags_q <= stack[sp-1]
  2. flag_we: flags_q <= flags_in
  3. otherwise hold
- Push (legal when not full): stack[sp] <= eff, sp <= sp+1. Pushing with flag_we in the same cycle saves the new flags.
- Stack state: stack_empty = (sp==0), stack_full = (sp==DEPTH). Both are registered, derived from next sp, and valid in the cycle after the operation.
- Illegal operations, each causing no state change except flag_we still applying, with stack_err=1 next cycle:
  - push while full
  - pop while empty
  - push and pop asserted together
- No wrap-around: sp saturates at 0 and DEPTH.
- A branch evaluated in the same cycle as a legal pop uses eff (pre-pop flags). Restored flags are visible from the next cycle.
- Reset asserted mid-operation clears all state immediately. No partial push/pop survives. A branch_valid pending for the next edge is dropped.

Test Plan:
- Reset then idle: rst=1 mid-cycle -> flags_q=000, stack_empty=1, branch_valid=0 asynchronously. After release, cond=001 with branch_req -> next cycle branch_valid=1, branch_taken=0.
- Forwarding: flags_q=000; same cycle flag_we=1, flags_in=3'b010, branch_req=1, cond=001 -> next cycle branch_taken=1, flags_q=010.
- Condition sweep: flags_q=3'b101 (N=1, C=1, Z=0); cond 000..111 on successive cycles -> branch_taken=1,0,1,1,0,1,0,0, with branch_valid high for 8 consecutive cycles.
- Stack fill/overflow (DEPTH=4): push flags 001,010,100,011 -> stack_full=1. Fifth push -> stack_err pulse, sp unchanged. Four pops -> flags_q=011,100,010,001 in order, then stack_empty=1.
- Underflow and conflicts: pop when empty -> stack_err=1, flags_q unchanged. push+pop together with one entry -> stack_err=1, sp stays 1. pop+flag_we(111) with top=010 -> flags_q=010.
- Reset mid-push: assert rst in the same cycle as push with sp=2 -> sp=0, stack_empty=1, no stack_err. Subsequent pop -> stack_err=1.
